// File: rtl/cog_clock_gen.sv
// Cog clock generator: phase accumulator in the fast PLL clock domain producing the cog clock
// level and cog/PLL enables, with glitch-free mode switching at cog-period boundaries.
`timescale 1ns/1ps
module cog_clock_gen #(
  parameter int ACC_W         = 13,
  parameter int SETTLE_W      = 16,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       nres,
  input  logic [6:0] cfg,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic [6:0] mode,
  output logic       switching,
  output logic       clk_cog,
  output logic       cog_en,
  output logic       pll_en
);

  // state  | meaning
  // IDLE   | mode stable, accepting a new cfg word
  // SETTLE | PLL just enabled, waiting SETTLE_CYCLES before aligning
  // ALIGN  | waiting for a cog-period boundary (carry) or frozen accumulator

  localparam int H = ACC_W - 1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ALIGN  = 2'd2;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  logic [1:0]          state;
  logic [6:0]          pending;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    inc;
  logic [ACC_W:0]      sum;
  logic [4:0]          clksel;
  logic                carry;
  logic                half_carry;
  logic                pll16x;
  logic                boundary;
  logic                pll_turn_on;

  assign clksel = {mode[6:5], mode[2:0]};
  assign pll16x = (clksel == 5'b11111);

  always_comb begin
    inc = '0;
    if (clksel == 5'b11111)
      inc = ACC_W'(1) << H;
    else if (clksel == 5'b11110)
      inc = ACC_W'(1) << (H - 1);
    else if (clksel == 5'b11101)
      inc = ACC_W'(1) << (H - 2);
    else if (clksel == 5'b11100 || clksel[2:0] == 3'b000)
      inc = ACC_W'(1) << (H - 3);
    else if (clksel == 5'b11011 || clksel == 5'b01010)
      inc = ACC_W'(1) << (H - 4);
    else if (clksel[2:0] == 3'b001)
      inc = ACC_W'(1);
  end

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = sum[ACC_W];
  // carry into bit H recovered from the sum bit, so no second adder is needed
  assign half_carry = sum[H] ^ acc[H] ^ inc[H];

  assign boundary    = (state == ST_ALIGN) && (carry || (inc == '0));
  assign pll_turn_on = (cfg[6:5] == 2'b11) && !mode[6];

  always_ff @(posedge clock or negedge nres) begin
    if (!nres) begin
      acc    <= '0;
      cog_en <= 1'b0;
      pll_en <= 1'b0;
    end else begin
      acc    <= boundary ? '0 : sum[ACC_W-1:0];
      cog_en <= carry;
      pll_en <= half_carry | pll16x;
    end
  end

  always_ff @(posedge clock or negedge nres) begin
    if (!nres) begin
      state      <= ST_IDLE;
      pending    <= '0;
      settle_cnt <= '0;
      mode       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            pending <= cfg;
            if (pll_turn_on) begin
              state      <= ST_SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              state <= ST_ALIGN;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt <= SETTLE_W'(1)) begin
            settle_cnt <= '0;
            state      <= ST_ALIGN;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        ST_ALIGN: begin
          if (boundary) begin
            mode  <= pending;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state == ST_IDLE);
  assign switching = (state != ST_IDLE);
  assign clk_cog   = acc[H];

endmodule

// File: tb/tb_cog_clock_gen.sv
// Directed bench for cog_clock_gen: table of mode switches with hand-computed switch latency
// and new-mode period, plus sequences for freeze, reset during settle and ignored offers.
`timescale 1ns/1ps
module tb_cog_clock_gen;

  localparam int LIMIT = 20000;

  logic       clock = 1'b0;
  logic       nres = 1'b0;
  logic [6:0] cfg = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [6:0] mode;
  logic       switching;
  logic       clk_cog;
  logic       cog_en;
  logic       pll_en;

  always #5 clock = ~clock;

  cog_clock_gen #(.ACC_W(13), .SETTLE_W(16), .SETTLE_CYCLES(8)) dut (
    .clock     (clock),
    .nres      (nres),
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .mode      (mode),
    .switching (switching),
    .clk_cog   (clk_cog),
    .cog_en    (cog_en),
    .pll_en    (pll_en)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // counts samples until the next cog_en, tallying pll_en pulses and clk_cog high samples
  task automatic measure(output int n, output int npll, output int nhigh);
    n = 0; npll = 0; nhigh = 0;
    do begin
      @(negedge clock);
      n++;
      if (pll_en) npll++;
      if (clk_cog) nhigh++;
    end while (!cog_en && n < LIMIT);
  endtask

  // offers cfg after 'phase' samples, returns number of samples with switching high
  task automatic offer(input logic [6:0] c, input int phase, output int nsw, output logic rdy);
    repeat (phase) @(negedge clock);
    cfg = c;
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    rdy = cfg_ready;
    nsw = 0;
    while (switching && nsw < LIMIT) begin
      nsw++;
      @(negedge clock);
    end
  endtask

  // clk_cog run-length monitor, sampled just after each falling edge
  int   run_len = 1;
  int   min_run = 99;
  logic prev_clk = 1'b0;
  bit   run_started = 1'b0;
  bit   runt_mon = 1'b0;

  always @(negedge clock) begin
    #1;
    if (runt_mon) begin
      if (clk_cog !== prev_clk) begin
        if (run_started && run_len < min_run) min_run = run_len;
        run_started = 1'b1;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_clk = clk_cog;
    end
  end

  typedef struct {
    logic [6:0] cfg;
    int         phase;
    int         sw;
    int         period;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n, npll, nhigh, nsw, cnt;
    logic rdy;

    vecs[0] = '{7'b1101111,  6,    9,    2};
    vecs[1] = '{7'b1100001,  0,    1, 8192};
    vecs[2] = '{7'b0100010,  0, 8191,   32};
    vecs[3] = '{7'b1101110, 23,   40,    4};
    vecs[4] = '{7'b1101101,  1,    2,    8};
    vecs[5] = '{7'b1101101,  3,    4,    8};
    vecs[6] = '{7'b1101100,  7,    8,   16};
    vecs[7] = '{7'b1101011,  0,   15,   32};
    vecs[8] = '{7'b0000000, 10,   21,   16};
    vecs[9] = '{7'b1111111, 15,   16,    2};

    repeat (3) @(negedge clock);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_switching", switching, 0);
    check("rst_mode", mode, 0);
    check("rst_outputs", {cog_en, pll_en, clk_cog}, 0);
    nres = 1'b1;

    measure(n, npll, nhigh);
    check("rcfast_first_cog_en", n, 16);
    check("rcfast_first_pll", npll, 2);
    check("rcfast_first_high", nhigh, 8);
    measure(n, npll, nhigh);
    check("rcfast_period", n, 16);
    check("rcfast_duty", nhigh, 8);

    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        prev_clk = clk_cog;
        run_started = 1'b0;
        run_len = 1;
        min_run = 99;
        runt_mon = 1'b1;
      end
      offer(vecs[i].cfg, vecs[i].phase, nsw, rdy);
      if (i == 0) begin
        #2 runt_mon = 1'b0;
        check("v0_min_clk_cog_run", min_run, 8);
      end
      check($sformatf("v%0d_ready_drop", i), rdy, 0);
      check($sformatf("v%0d_switch_cycles", i), nsw, vecs[i].sw);
      check($sformatf("v%0d_mode", i), mode, vecs[i].cfg);
      check($sformatf("v%0d_boundary_cog_en", i), cog_en, 1);
      measure(n, npll, nhigh);
      check($sformatf("v%0d_period", i), n, vecs[i].period);
      check($sformatf("v%0d_pll_pulses", i), npll, 2);
      check($sformatf("v%0d_high_samples", i), nhigh, vecs[i].period / 2);
    end

    // reserved code freezes the accumulator, then RCFAST aligns immediately
    offer(7'b0000011, 0, nsw, rdy);
    check("frz_switch_cycles", nsw, 1);
    check("frz_mode", mode, 7'b0000011);
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (cog_en || pll_en || clk_cog) cnt++;
    end
    check("frz_outputs_quiet", cnt, 0);
    offer(7'b0000000, 0, nsw, rdy);
    check("unfrz_switch_cycles", nsw, 1);
    check("unfrz_no_carry", cog_en, 0);
    measure(n, npll, nhigh);
    check("unfrz_period", n, 16);
    check("unfrz_high", nhigh, 8);

    // reset in the middle of SETTLE discards the pending switch
    cfg = 7'b1101111;
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rs_in_settle", switching, 1);
    nres = 1'b0;
    #1;
    check("rs_async_switching", switching, 0);
    check("rs_async_ready", cfg_ready, 1);
    check("rs_async_mode", mode, 0);
    check("rs_async_outputs", {cog_en, pll_en, clk_cog}, 0);
    @(negedge clock);
    nres = 1'b1;
    measure(n, npll, nhigh);
    check("rs_period", n, 16);
    check("rs_mode_kept", mode, 0);
    check("rs_idle", switching, 0);

    // second offer during a switch is ignored
    offer_ignored: begin
      cfg = 7'b1101101;
      cfg_valid = 1'b1;
      @(negedge clock);
      cfg_valid = 1'b0;
      n = 0;
      while (switching && n < LIMIT) begin
        if (n == 2) begin
          cfg = 7'b1100001;
          cfg_valid = 1'b1;
          check("ign_ready_low", cfg_ready, 0);
        end else begin
          cfg_valid = 1'b0;
        end
        n++;
        @(negedge clock);
      end
      cfg_valid = 1'b0;
    end
    check("ign_switch_cycles", n, 15);
    check("ign_mode", mode, 7'b1101101);
    measure(n, npll, nhigh);
    check("ign_period", n, 8);
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (switching) cnt++;
    end
    check("ign_no_second_switch", cnt, 0);
    check("ign_mode_final", mode, 7'b1101101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
